// File: rtl/bus_responder.sv
// ============================================================================
// bus_responder - single-word read/write responder on a flop-based memory,
// each access stretched by LATENCY busy cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_responder #(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [31:0]       cpu_dat_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       cpu_dat_o,
  output logic              busy_o
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [31:0]         rdat_q, rdat_d;
  logic                busy_q, busy_d;
  logic                mem_we;
  logic [31:0]         mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      wr_q    <= 1'b0;
      rdat_q  <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rdat_q  <= rdat_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    rdat_d  = rdat_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // write_i has priority; a coincident read is simply dropped
        if (write_i || read_i) begin
          adr_d   = adr_i;
          dat_d   = cpu_dat_i;
          sel_d   = sel_i;
          wr_d    = write_i;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdat_d = mem_q[adr_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  generate
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[w] <= 32'd0;
        end else if (mem_we && (adr_q == ADDR_W'(w))) begin
          for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) begin
              mem_q[w][8*b +: 8] <= dat_q[8*b +: 8];
            end
          end
        end
      end
    end
  endgenerate

  assign cpu_dat_o = rdat_q;
  assign busy_o    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// ============================================================================
// tb_bus_responder - directed bench for bus_responder with a transaction-level
// reference model compared every cycle. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_responder;

  localparam int ADDR_W = 5;
  localparam int LAT    = 2;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              read_i = 1'b0;
  logic              write_i = 1'b0;
  logic [ADDR_W-1:0] adr_i = '0;
  logic [31:0]       cpu_dat_i = 32'd0;
  logic [3:0]        sel_i = 4'd0;
  logic [31:0]       cpu_dat_o;
  logic              busy_o;

  bus_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .adr_i     (adr_i),
    .cpu_dat_i (cpu_dat_i),
    .sel_i     (sel_i),
    .cpu_dat_o (cpu_dat_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Transaction-level model: a request accepted at edge S completes at S+LAT.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_dout;
  bit          m_active;
  bit          m_wr;
  int          m_start;
  int          edge_n = 0;
  logic [4:0]  m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_dout   = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
  endtask

  task automatic model_step();
    edge_n++;
    if (m_active) begin
      if (edge_n == m_start + LAT) begin
        if (m_wr) begin
          for (int b = 0; b < 4; b++)
            if (m_sel[b]) m_mem[m_adr][8*b +: 8] = m_dat[8*b +: 8];
        end else begin
          m_dout = m_mem[m_adr];
        end
        m_active = 1'b0;
      end
    end else if (write_i || read_i) begin
      m_wr     = write_i;
      m_adr    = adr_i;
      m_dat    = cpu_dat_i;
      m_sel    = sel_i;
      m_start  = edge_n;
      m_active = 1'b1;
    end
  endtask

  initial begin : compare_loop
    forever begin
      @(posedge clk);
      if (!rst) model_step();
      #1;
      if (cmp_en && !rst) begin
        check("busy_o", {31'd0, busy_o}, {31'd0, m_active});
        check("cpu_dat_o", cpu_dat_o, m_dout);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy_o && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (busy_o) check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after completion.
  task automatic req(input logic r, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    read_i = r; write_i = w; adr_i = a; cpu_dat_i = d; sel_i = s;
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0;
    wait_idle();
  endtask

  logic [4:0]  h_adr [3] = '{5'd5, 5'd7, 5'd3};
  logic [31:0] h_exp [3] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0000CAFE};

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    req(1'b0, 1'b1, 5'd1, 32'h12345678, 4'hF);
    req(1'b1, 1'b0, 5'd1, 32'd0, 4'h0);
    check("rd_pre_reset", cpu_dat_o, 32'h12345678);

    // Asynchronous reset in the middle of a read
    read_i = 1'b1; adr_i = 5'd1;
    @(negedge clk);
    read_i = 1'b0;
    check("busy_before_rst", {31'd0, busy_o}, 32'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_dout", cpu_dat_o, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      req(1'b1, 1'b0, 5'(a), 32'd0, 4'h0);
      check("rd_after_rst", cpu_dat_o, 32'd0);
    end

    req(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    req(1'b1, 1'b0, 5'd5, 32'd0, 4'h0);
    check("wr_rd_5", cpu_dat_o, 32'hDEADBEEF);

    req(1'b0, 1'b1, 5'd7, 32'h11223344, 4'hF);
    req(1'b0, 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101);
    req(1'b1, 1'b0, 5'd7, 32'd0, 4'h0);
    check("sel_0101", cpu_dat_o, 32'h11BB33DD);
    req(1'b0, 1'b1, 5'd7, 32'hFFFFFFFF, 4'b0000);
    req(1'b1, 1'b0, 5'd7, 32'd0, 4'h0);
    check("sel_0000", cpu_dat_o, 32'h11BB33DD);

    req(1'b1, 1'b1, 5'd3, 32'h0000CAFE, 4'hF);
    check("simul_keep_dout", cpu_dat_o, 32'h11BB33DD);
    req(1'b1, 1'b0, 5'd3, 32'd0, 4'h0);
    check("simul_rd_3", cpu_dat_o, 32'h0000CAFE);

    // Held read with address churn while busy
    k = 0;
    read_i = 1'b1; adr_i = h_adr[0];
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      check("held_busy", {31'd0, busy_o}, (cyc % 3 != 2) ? 32'd1 : 32'd0);
      if (!busy_o) begin
        if (k < 3) check("held_data", cpu_dat_o, h_exp[k]);
        k++;
        if (k < 3) adr_i = h_adr[k];
        else read_i = 1'b0;
      end else begin
        adr_i = 5'($urandom_range(0, 31));
      end
    end
    read_i = 1'b0;
    wait_idle();

    // Reset after edge T+1 of a write, before its completion edge
    write_i = 1'b1; adr_i = 5'd9; cpu_dat_i = 32'h99999999; sel_i = 4'hF;
    @(negedge clk);
    write_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_wr_busy", {31'd0, busy_o}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 5'd9, 32'd0, 4'h0);
    check("rst_wr_mem9", cpu_dat_o, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
